// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL.
// Define ALU_MC_DIV_EN to add an iterative restoring UDIV (opcode 1010).
module alu_mc #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b1,
  input  logic [3:0]   ALUControl,
  input  logic         start,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam int SW = $clog2(N);

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
  } state_t;
`endif

  state_t        state;
  logic [SW-1:0] cnt;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcd;
  logic [N-1:0]  mpl;
  logic [N-1:0]  alu_y;
  logic [N-1:0]  acc_nx;
  logic [SW-1:0] shamt;

  assign shamt = b1[SW-1:0];
  assign busy  = (state != IDLE);

  always_comb begin
    alu_y = '0;
    case (ALUControl)
      4'b0000: alu_y = a & b1;
      4'b0001: alu_y = a | b1;
      4'b0010: alu_y = a + b1;
      4'b0110: alu_y = a - b1;
      4'b0111: alu_y = b1;
      4'b1100: alu_y = ~(a | b1);
      4'b0011: alu_y = a << shamt;
      4'b0100: alu_y = a >> shamt;
      default: alu_y = '0;
    endcase
  end

  // MUL: acc accumulates, mcd is the shifted multiplicand, mpl the multiplier
  assign acc_nx = mpl[0] ? acc + mcd : acc;

`ifdef ALU_MC_DIV_EN
  // DIV reuses acc as remainder, mpl as dividend/quotient, mcd as divisor
  logic [N:0]   rsh;
  logic [N:0]   rdf;
  logic         ge;
  logic [N-1:0] rem_nx;
  logic [N-1:0] quo_nx;
  logic         dz;

  assign rsh    = {acc, mpl[N-1]};
  assign ge     = (rsh >= {1'b0, mcd});
  assign rdf    = rsh - {1'b0, mcd};
  assign rem_nx = ge ? rdf[N-1:0] : rsh[N-1:0];
  assign quo_nx = {mpl[N-2:0], ge};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcd    <= '0;
      mpl    <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
`ifdef ALU_MC_DIV_EN
      dz     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ALUControl == 4'b1000) begin
              state <= MUL;
              acc   <= '0;
              mcd   <= a;
              mpl   <= b1;
              cnt   <= SW'(N - 1);
`ifdef ALU_MC_DIV_EN
            end else if (ALUControl == 4'b1010) begin
              state <= DIV;
              acc   <= '0;
              mcd   <= b1;
              mpl   <= a;
              dz    <= (b1 == '0);
              cnt   <= SW'(N - 1);
`endif
            end else begin
              result <= alu_y;
              zero   <= (alu_y == '0);
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_nx;
          mcd <= mcd << 1;
          mpl <= mpl >> 1;
          cnt <= cnt - SW'(1);
          if (cnt == '0) begin
            state  <= IDLE;
            result <= acc_nx;
            zero   <= (acc_nx == '0);
            done   <= 1'b1;
          end
        end
`ifdef ALU_MC_DIV_EN
        DIV: begin
          acc <= rem_nx;
          mpl <= quo_nx;
          cnt <= cnt - SW'(1);
          if (cnt == '0) begin
            state  <= IDLE;
            result <= dz ? '0 : quo_nx;
            zero   <= dz | (quo_nx == '0);
            done   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (N=64): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_mc;

  localparam int N  = 64;
  localparam int SW = $clog2(N);

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] a;
  logic [N-1:0] b1;
  logic [3:0]   ALUControl;
  logic         start;
  logic [N-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b1        (b1),
    .ALUControl(ALUControl),
    .start     (start),
    .result    (result),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag,
                     input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input logic [3:0] op,
                                          input logic [N-1:0] x,
                                          input logic [N-1:0] y);
    int unsigned sh;
    sh = int'(y % N);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return y;
      4'b1100: return ~(x | y);
      4'b0011: return x << sh;
      4'b0100: return x >> sh;
      4'b1000: return x * y;
`ifdef ALU_MC_DIV_EN
      4'b1010: return (y == 0) ? '0 : x / y;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic bit is_multi(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == 4'b1000) || (op == 4'b1010);
`else
    return (op == 4'b1000);
`endif
  endfunction

  // Issue one op at posedge+1; noisy=1 pulses start/changes inputs while busy
  task automatic run_op(input logic [3:0] op,
                        input logic [N-1:0] x,
                        input logic [N-1:0] y,
                        input bit noisy);
    logic [N-1:0] exp;
    int cyc;
    int busy_bad;
    exp = ref_op(op, x, y);
    ALUControl = op;
    a = x;
    b1 = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!is_multi(op)) begin
      chk("sc_done", done, 1);
      chk("sc_busy", busy, 0);
      chk("sc_result", result, exp);
      chk("sc_zero", zero, exp == 0);
    end else begin
      chk("mc_busy0", busy, 1);
      chk("mc_done0", done, 0);
      cyc = 0;
      busy_bad = 0;
      while (done !== 1'b1 && cyc < 200) begin
        if (noisy) begin
          a = {$urandom, $urandom};
          b1 = {$urandom, $urandom};
          ALUControl = 4'($urandom);
          start = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        if (done !== 1'b1 && busy !== 1'b1) busy_bad++;
      end
      chk("mc_latency", cyc, N);
      chk("mc_busy_run", busy_bad, 0);
      chk("mc_busy_end", busy, 0);
      chk("mc_result", result, exp);
      chk("mc_zero", zero, exp == 0);
    end
    @(posedge clk); #1;
    chk("done_once", done, 0);
    chk("hold", result, exp);
  endtask

  initial begin
    logic [3:0]   op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    int           seen;
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b1 = '0;
    ALUControl = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'b0010, 64'd5, 64'd7, 0);
    run_op(4'b0110, 64'd9, 64'd9, 0);
    run_op(4'b0011, 64'd1, 64'd70, 0);
    chk("lsl70", result, 64'd64);
    run_op(4'b0100, 64'h8000_0000_0000_0000, 64'd63, 0);
    run_op(4'b0010, '1, 64'd1, 0);
    run_op(4'b1100, 64'h0F0F, 64'hF000, 0);
    run_op(4'b1111, 64'd3, 64'd4, 0);
    run_op(4'b1000, '1, 64'd3, 1);
    chk("mul_ffff", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'b1010, 64'd100, 64'd7, 0);
    run_op(4'b1010, 64'd5, 64'd0, 0);
    chk("div0_zero", zero, 1);

    // back-to-back: start held in the done cycle is accepted
    ALUControl = 4'b0010;
    a = 64'd2;
    b1 = 64'd3;
    start = 1'b1;
    @(posedge clk); #1;
    ALUControl = 4'b0110;
    a = 64'd10;
    b1 = 64'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_result", result, 64'd6);
    @(posedge clk); #1;

    // reset mid-clock during cycle 20 of a MUL
    ALUControl = 4'b1000;
    a = 64'd12345;
    b1 = 64'd678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("abort_quiet", seen, 0);
    run_op(4'b0010, 64'd1, 64'd1, 0);
    chk("post_rst_add", result, 64'd2);

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      x = {$urandom, $urandom};
      y = (i % 3 == 0) ? N'($urandom_range(0, 200)) : {$urandom, $urandom};
      if (i % 7 == 0) x = '0;
      run_op(op, x, y, (i % 2) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the operand and result width in bits (power of two, 8 to 64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a, input, N bits: first operand.
REQ-005 The block SHALL have port b1, input, N bits: second operand.
REQ-006 The block SHALL have port ALUControl, input, 4 bits: operation select.
REQ-007 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-008 The block SHALL have port result, output, N bits: registered result of the last completed operation.
REQ-009 The block SHALL have port zero, output, 1 bit: high when the registered result equals 0.
REQ-010 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when result/zero have just been updated.

Function
REQ-012 Opcodes SHALL be: 0000 a AND b1; 0001 a OR b1; 0010 a+b1; 0110 a-b1; 0111 pass b1; 1100 NOR; 0011 a << b1[log2(N)-1:0]; 0100 a >> b1[log2(N)-1:0] (logical); 1000 MUL (low N bits of a*b1, unsigned); 1010 UDIV (see Configuration); any other code gives result 0.
REQ-013 Add/sub SHALL be modulo 2^N, with the carry/borrow discarded.
REQ-014 FSM states SHALL be IDLE, MUL, DIV; busy SHALL be 1 exactly when the state is not IDLE.
REQ-015 start SHALL be sampled only in IDLE; start while busy SHALL be ignored, with no queuing.
REQ-016 a, b1 and ALUControl SHALL be captured at the accepting edge; later changes SHALL NOT affect the operation in flight.
REQ-017 Single-cycle ops: result and zero SHALL update at the accepting edge, done SHALL be 1 for the following cycle, and the state SHALL stay IDLE.
REQ-018 MUL: IDLE->MUL at the accepting edge; one shift-add iteration per cycle for N cycles via a down-counter; at the Nth edge result/zero SHALL update, state SHALL go to IDLE, and done SHALL pulse for one cycle; start-to-done latency SHALL be N cycles.
REQ-019 A start seen in the cycle done is high SHALL be accepted (back-to-back operation).
REQ-020 result and zero SHALL hold between completions; done SHALL never be high for two consecutive cycles from a single operation.
REQ-021 zero SHALL equal (result == 0) at all times, registered together with result.

Reset
REQ-022 On reset assertion, independent of clk: state=IDLE, counter=0, result=0, zero=1, busy=0, done=0.
REQ-023 Reset during MUL or DIV SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-024 Macro ALU_MC_DIV_EN defined: opcode 1010 SHALL perform unsigned restoring division a/b1 in DIV state, N iterations, with the same latency and handshake as MUL; b1=0 SHALL give result 0.
REQ-025 Macro ALU_MC_DIV_EN undefined: there SHALL be no DIV state or divider logic; opcode 1010 SHALL act as an undefined code (result 0, single-cycle).

Verification (N=64)
REQ-026 ADD a=5, b1=7, start one cycle -> next cycle done=1, result=12, zero=0, busy=0 throughout.
REQ-027 SUB a=9, b1=9 -> result=0, zero=1; then LSL a=1, b1=70 -> result=64 (shift amount 6).
REQ-028 MUL a=0xFFFFFFFFFFFFFFFF, b1=3; start pulsed again and operands changed during busy -> busy for 64 cycles, single done, result=0xFFFFFFFFFFFFFFFD.
REQ-029 ALU_MC_DIV_EN defined: UDIV 100/7 -> result 14 after 64 cycles; UDIV 5/0 -> result 0, zero=1. Undefined: opcode 1010 -> result 0 after one cycle, busy never high.
REQ-030 Reset asserted mid-clock in cycle 20 of a MUL -> immediately busy=0, done=0, result=0, zero=1; no done pulse afterwards; a following ADD 1+1 returns 2.
